// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a request/ready instruction memory port,
// and holds the IF/ID register, discarding wrong-path fetches after branch/jump redirects.
//
// state | meaning
// FETCH | request outstanding at pc; normal fetch/advance
// DRAIN | wrong-path request still in flight; wait for ready, then go to redirect_pc
// HOLD  | word fetched under stall is parked in skid; no request issued
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] redirect_pc, redirect_pc_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_pc4, skid_pc4_n;
  logic [31:0] instr_n, pc4_n;
  logic        valid_n;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign redirect = branch_taken | (jump & ~stall);
  assign target   = branch_taken ? branch_target : jump_target;
  assign pc_plus4 = pc + 32'd4;

  // Request depends only on state/pc so the address stays stable while waiting for ready.
  assign imem_req  = ~rst & (state != HOLD);
  assign imem_addr = {pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      redirect_pc    <= 32'h0;
      skid_instr     <= 32'h0;
      skid_pc4       <= 32'h0;
      if_id_instr    <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid    <= 1'b0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      redirect_pc    <= redirect_pc_n;
      skid_instr     <= skid_instr_n;
      skid_pc4       <= skid_pc4_n;
      if_id_instr    <= instr_n;
      if_id_pc_plus4 <= pc4_n;
      if_id_valid    <= valid_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    redirect_pc_n = redirect_pc;
    skid_instr_n  = skid_instr;
    skid_pc4_n    = skid_pc4;
    instr_n       = if_id_instr;
    pc4_n         = if_id_pc_plus4;
    valid_n       = if_id_valid;

    case (state)
      FETCH: begin
        if (redirect) begin
          instr_n = 32'h0;
          valid_n = 1'b0;
          if (imem_ready) begin
            pc_n = target;
          end else begin
            redirect_pc_n = target;
            state_n       = DRAIN;
          end
        end else if (imem_ready) begin
          pc_n = pc_plus4;
          if (stall) begin
            skid_instr_n = imem_rdata;
            skid_pc4_n   = pc_plus4;
            state_n      = HOLD;
          end else begin
            instr_n = imem_rdata;
            pc4_n   = pc_plus4;
            valid_n = 1'b1;
          end
        end else if (!stall) begin
          instr_n = 32'h0;
          valid_n = 1'b0;
        end
      end

      DRAIN: begin
        instr_n = 32'h0;
        valid_n = 1'b0;
        if (redirect) redirect_pc_n = target;
        // A redirect arriving with ready is the newest target and must win.
        if (imem_ready) begin
          pc_n    = redirect ? target : redirect_pc;
          state_n = FETCH;
        end
      end

      HOLD: begin
        if (redirect) begin
          instr_n = 32'h0;
          valid_n = 1'b0;
          pc_n    = target;
          state_n = FETCH;
        end else if (!stall) begin
          instr_n = skid_instr;
          pc4_n   = skid_pc4;
          valid_n = 1'b1;
          state_n = FETCH;
        end
      end

      default: begin
        state_n = FETCH;
        instr_n = 32'h0;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule
